freq_div_ctrl: RTL and testbench

Run-time controller for a divided-tick generator. It produces a one-cycle `tick_o` strobe every `div_o` cycles of `clk_i`. It accepts new divide ratios through a valid/ready handshake and applies them only at a period boundary, so no period is ever shortened. It supports continuous and fixed-length burst modes with start/stop sequencing, and sits between the system control plane and any logic that consumes a divided clock enable.

---
 rtl/freq_div_ctrl.sv | 157 +++++++++++++++
 tb/tb_freq_div_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/freq_div_ctrl.sv
// freq_div_ctrl: divided-tick generator with handshaked ratio updates applied at period
// boundaries, continuous/burst modes and graceful stop. Macro FREQ_DIV_CTRL_STAT_EN adds tick_cnt_o.
`timescale 1ns/1ps
module freq_div_ctrl #(
  parameter int unsigned DIV_WIDTH   = 16,
  parameter int unsigned BURST_WIDTH = 16,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic                   clk_i,
  input  logic                   a_rst_i,
  input  logic [DIV_WIDTH-1:0]   cfg_div_i,
  input  logic                   cfg_valid_i,
  output logic                   cfg_ready_o,
  output logic                   cfg_err_o,
  input  logic [BURST_WIDTH-1:0] burst_len_i,
  input  logic                   start_i,
  input  logic                   stop_i,
  output logic                   tick_o,
  output logic                   busy_o,
  output logic                   done_o,
`ifdef FREQ_DIV_CTRL_STAT_EN
  output logic [31:0]            tick_cnt_o,
`endif
  output logic [DIV_WIDTH-1:0]   div_o
);

  localparam logic [DIV_WIDTH-1:0]   DIV_RST   = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH-1:0]   DIV_ONE   = DIV_WIDTH'(1);
  localparam logic [BURST_WIDTH-1:0] BURST_ONE = BURST_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t                 state_q, state_d;
  logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
  logic [BURST_WIDTH-1:0] rem_q, rem_d;
  logic [DIV_WIDTH-1:0]   div_q, div_d;
  logic [DIV_WIDTH-1:0]   pend_div_q, pend_div_d;
  logic                   pend_q, pend_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   tick;
  logic                   cfg_fire;
  logic                   cfg_zero;
  logic [DIV_WIDTH-1:0]   seed_div;

  assign tick      = (state_q != IDLE) && (cnt_q == '0);
  assign cfg_fire  = cfg_valid_i && !pend_q;
  assign cfg_zero  = (cfg_div_i == '0);

  assign tick_o      = tick;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign cfg_err_o   = err_q;
  assign cfg_ready_o = !pend_q;
  assign div_o       = div_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    div_d      = div_q;
    pend_d     = pend_q;
    pend_div_d = pend_div_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    seed_div   = div_q;

    if (cfg_fire) begin
      if (cfg_zero) begin
        err_d = 1'b1;
      end else if (state_q == IDLE) begin
        div_d = cfg_div_i;
      end else begin
        pend_d     = 1'b1;
        pend_div_d = cfg_div_i;
      end
    end

    unique case (state_q)
      IDLE: begin
        // A value captured during the final tick of a run lands here.
        if (pend_q) begin
          div_d  = pend_div_q;
          pend_d = 1'b0;
        end
        if (cfg_fire && !cfg_zero) seed_div = cfg_div_i;
        else if (pend_q)           seed_div = pend_div_q;
        if (start_i && !stop_i) begin
          state_d = RUN;
          cnt_d   = seed_div - DIV_ONE;
          rem_d   = burst_len_i;
        end
      end
      RUN, STOPPING: begin
        if (tick) begin
          if (pend_q) begin
            div_d  = pend_div_q;
            pend_d = 1'b0;
            cnt_d  = pend_div_q - DIV_ONE;
          end else begin
            cnt_d  = div_q - DIV_ONE;
          end
          if (rem_q != '0) rem_d = rem_q - BURST_ONE;
          if ((rem_q == BURST_ONE) || (state_q == STOPPING) || stop_i) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - DIV_ONE;
          if (stop_i) state_d = STOPPING;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or posedge a_rst_i) begin
    if (a_rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      div_q      <= DIV_RST;
      pend_q     <= 1'b0;
      pend_div_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_div_q <= pend_div_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

`ifdef FREQ_DIV_CTRL_STAT_EN
  logic [31:0] tick_cnt_q;

  always_ff @(posedge clk_i or posedge a_rst_i) begin
    if (a_rst_i) begin
      tick_cnt_q <= '0;
    end else if ((state_q == IDLE) && (state_d == RUN)) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= tick_cnt_q + 32'd1;
    end
  end

  assign tick_cnt_o = tick_cnt_q;
`endif

endmodule

// File: tb/tb_freq_div_ctrl.sv
// tb_freq_div_ctrl: table-driven cycle vectors checked through a scoreboard queue,
// plus a hand-written asynchronous-reset sequence.
`timescale 1ns/1ps
module tb_freq_div_ctrl;

  logic        clk = 1'b0;
  logic        a_rst = 1'b1;
  logic [15:0] cfg_div = '0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic        cfg_err;
  logic [15:0] burst_len = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        tick;
  logic        busy;
  logic        done;
  logic [15:0] div;
`ifdef FREQ_DIV_CTRL_STAT_EN
  logic [31:0] tick_cnt;
`endif

  freq_div_ctrl #(.DIV_WIDTH(16), .BURST_WIDTH(16), .DEFAULT_DIV(2)) dut (
    .clk_i       (clk),
    .a_rst_i     (a_rst),
    .cfg_div_i   (cfg_div),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
    .cfg_err_o   (cfg_err),
    .burst_len_i (burst_len),
    .start_i     (start),
    .stop_i      (stop),
    .tick_o      (tick),
    .busy_o      (busy),
    .done_o      (done),
`ifdef FREQ_DIV_CTRL_STAT_EN
    .tick_cnt_o  (tick_cnt),
`endif
    .div_o       (div)
  );

  always #5 clk = ~clk;

  // Expected outputs packed as {tick, busy, done, ready, err, div[15:0]}.
  typedef struct {
    logic        st;
    logic        sp;
    logic        cv;
    logic [15:0] cd;
    logic [15:0] bl;
    logic [20:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [20:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic void add(input logic st, input logic sp, input logic cv,
                              input logic [15:0] cd, input logic [15:0] bl,
                              input logic t, input logic b, input logic d,
                              input logic r, input logic e, input logic [15:0] dv);
    vec_t v;
    v.st  = st; v.sp = sp; v.cv = cv; v.cd = cd; v.bl = bl;
    v.exp = {t, b, d, r, e, dv};
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [20:0] outs();
    return {tick, busy, done, cfg_ready, cfg_err, div};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    // Continuous run at the reset divide of 2, then graceful stop.
    add(1,0,0,16'd0,16'd0, 0,1,0,1,0,16'd2);
    for (int k = 1; k <= 6; k++) add(0,0,0,16'd0,16'd0, logic'(k % 2), 1,0,1,0,16'd2);
    add(0,1,0,16'd0,16'd0, 1,1,0,1,0,16'd2);
    add(0,0,0,16'd0,16'd0, 0,0,1,1,0,16'd2);
    add(0,0,0,16'd0,16'd0, 0,0,0,1,0,16'd2);
    // Divide 5 written in IDLE, burst of 3.
    add(0,0,1,16'd5,16'd0, 0,0,0,1,0,16'd5);
    add(1,0,0,16'd0,16'd3, 0,1,0,1,0,16'd5);
    for (int k = 1; k <= 16; k++)
      add(0,0,0,16'd0,16'd0, (k==4)||(k==9)||(k==14), k<=14, k==15, 1,0,16'd5);
    // Divide 4 running, 7 written mid-period, later a zero write, then stop.
    add(0,0,1,16'd4,16'd0, 0,0,0,1,0,16'd4);
    add(1,0,0,16'd0,16'd0, 0,1,0,1,0,16'd4);
    for (int k = 1; k <= 33; k++)
      add(0, k==26, (k==1)||(k==19), (k==1) ? 16'd7 : 16'd0, 16'd0,
          (k==3)||(k==10)||(k==17)||(k==24)||(k==31), k<=31, k==32,
          !((k>=1)&&(k<=3)), k==19, (k>=4) ? 16'd7 : 16'd4);
    // Divide 3, stop one cycle after a tick; then start+stop in IDLE.
    add(0,0,1,16'd3,16'd0, 0,0,0,1,0,16'd3);
    add(1,0,0,16'd0,16'd0, 0,1,0,1,0,16'd3);
    for (int k = 1; k <= 10; k++)
      add(0, k==7, 0,16'd0,16'd0, (k==2)||(k==5)||(k==8), k<=8, k==9, 1,0,16'd3);
    add(1,1,0,16'd0,16'd0, 0,0,0,1,0,16'd3);
    add(0,1,0,16'd0,16'd0, 0,0,0,1,0,16'd3);
    add(0,0,0,16'd0,16'd0, 0,0,0,1,0,16'd3);
    // Divide 1, burst of 2; zero write in IDLE.
    add(0,0,1,16'd1,16'd0, 0,0,0,1,0,16'd1);
    add(1,0,0,16'd0,16'd2, 1,1,0,1,0,16'd1);
    add(0,0,0,16'd0,16'd0, 1,1,0,1,0,16'd1);
    add(0,0,0,16'd0,16'd0, 0,0,1,1,0,16'd1);
    add(0,0,1,16'd0,16'd0, 0,0,0,1,1,16'd1);
    add(0,0,0,16'd0,16'd0, 0,0,0,1,0,16'd1);
    // Config coinciding with start seeds the first period; stop lands in a tick cycle.
    add(1,0,1,16'd4,16'd0, 0,1,0,1,0,16'd4);
    add(0,0,0,16'd0,16'd0, 0,1,0,1,0,16'd4);
    add(0,0,0,16'd0,16'd0, 0,1,0,1,0,16'd4);
    add(0,0,0,16'd0,16'd0, 1,1,0,1,0,16'd4);
    add(0,1,0,16'd0,16'd0, 0,0,1,1,0,16'd4);
    add(0,0,0,16'd0,16'd0, 0,0,0,1,0,16'd4);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'(outs()), 32'({1'b0,1'b0,1'b0,1'b1,1'b0,16'd2}));
    a_rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      start     = vecs[i].st;
      stop      = vecs[i].sp;
      cfg_valid = vecs[i].cv;
      cfg_div   = vecs[i].cd;
      burst_len = vecs[i].bl;
      exp_q.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        check($sformatf("vec%0d_scoreboard_empty", i), 32'd1, 32'd0);
      end else begin
        check($sformatf("vec%0d", i), 32'(outs()), 32'(exp_q.pop_front()));
      end
    end
    start = 1'b0; stop = 1'b0; cfg_valid = 1'b0; cfg_div = '0; burst_len = '0;

    // Asynchronous reset mid-burst while a tick is high (div is 4 here).
    start = 1'b1; burst_len = 16'd5;
    @(posedge clk); #1;
    start = 1'b0; burst_len = '0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_tick", {31'd0, tick}, 32'd1);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    #3;
    a_rst = 1'b1;
    #1;
    check("async_reset_outputs", 32'(outs()), 32'({1'b0,1'b0,1'b0,1'b1,1'b0,16'd2}));
    @(posedge clk); #1;
    a_rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check($sformatf("post_reset_quiet%0d", k), {30'd0, busy, done}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
